// File: rtl/riscv_biu_mux_if.sv
// Bundle of the two upstream master ports and the single downstream BIU port.
// The slave modport is the mux view; the master modport is the surrounding environment.
interface riscv_biu_mux_if #(
    parameter int XLEN = 64,
    parameter int PLEN = 64
);
    logic            mst0_stb_i,     mst1_stb_i;
    logic            mst0_stb_ack_o, mst1_stb_ack_o;
    logic            mst0_d_ack_o,   mst1_d_ack_o;
    logic [PLEN-1:0] mst0_adri_i,    mst1_adri_i;
    logic [PLEN-1:0] mst0_adro_o,    mst1_adro_o;
    logic [2:0]      mst0_size_i,    mst1_size_i;
    logic [2:0]      mst0_type_i,    mst1_type_i;
    logic [2:0]      mst0_prot_i,    mst1_prot_i;
    logic            mst0_lock_i,    mst1_lock_i;
    logic            mst0_we_i,      mst1_we_i;
    logic [XLEN-1:0] mst0_d_i,       mst1_d_i;
    logic [XLEN-1:0] mst0_q_o,       mst1_q_o;
    logic            mst0_ack_o,     mst1_ack_o;
    logic            mst0_err_o,     mst1_err_o;

    logic            biu_stb_o;
    logic            biu_stb_ack_i;
    logic            biu_d_ack_i;
    logic [PLEN-1:0] biu_adri_o;
    logic [PLEN-1:0] biu_adro_i;
    logic [2:0]      biu_size_o, biu_type_o, biu_prot_o;
    logic            biu_lock_o, biu_we_o;
    logic [XLEN-1:0] biu_d_o;
    logic [XLEN-1:0] biu_q_i;
    logic            biu_ack_i, biu_err_i;

    modport slave (
        input  mst0_stb_i, mst1_stb_i,
        output mst0_stb_ack_o, mst1_stb_ack_o,
        output mst0_d_ack_o, mst1_d_ack_o,
        input  mst0_adri_i, mst1_adri_i,
        output mst0_adro_o, mst1_adro_o,
        input  mst0_size_i, mst1_size_i,
        input  mst0_type_i, mst1_type_i,
        input  mst0_prot_i, mst1_prot_i,
        input  mst0_lock_i, mst1_lock_i,
        input  mst0_we_i, mst1_we_i,
        input  mst0_d_i, mst1_d_i,
        output mst0_q_o, mst1_q_o,
        output mst0_ack_o, mst1_ack_o,
        output mst0_err_o, mst1_err_o,
        output biu_stb_o,
        input  biu_stb_ack_i, biu_d_ack_i,
        output biu_adri_o,
        input  biu_adro_i,
        output biu_size_o, biu_type_o, biu_prot_o,
        output biu_lock_o, biu_we_o, biu_d_o,
        input  biu_q_i, biu_ack_i, biu_err_i
    );

    modport master (
        output mst0_stb_i, mst1_stb_i,
        input  mst0_stb_ack_o, mst1_stb_ack_o,
        input  mst0_d_ack_o, mst1_d_ack_o,
        output mst0_adri_i, mst1_adri_i,
        input  mst0_adro_o, mst1_adro_o,
        output mst0_size_i, mst1_size_i,
        output mst0_type_i, mst1_type_i,
        output mst0_prot_i, mst1_prot_i,
        output mst0_lock_i, mst1_lock_i,
        output mst0_we_i, mst1_we_i,
        output mst0_d_i, mst1_d_i,
        input  mst0_q_o, mst1_q_o,
        input  mst0_ack_o, mst1_ack_o,
        input  mst0_err_o, mst1_err_o,
        input  biu_stb_o,
        output biu_stb_ack_i, biu_d_ack_i,
        input  biu_adri_o,
        output biu_adro_i,
        input  biu_size_o, biu_type_o, biu_prot_o,
        input  biu_lock_o, biu_we_o, biu_d_o,
        output biu_q_i, biu_ack_i, biu_err_i
    );
endinterface

// File: rtl/riscv_biu_mux.sv
// Two-master BIU arbiter: round-robin request grant with lock support and an
// owner queue that steers data-phase and ack-phase responses back to their master.
module riscv_biu_mux #(
    parameter int XLEN   = 64,
    parameter int PLEN   = 64,
    parameter int QDEPTH = 4
) (
    input logic                HCLK,
    input logic                HRESETn,
    riscv_biu_mux_if.slave     bus_io
);
    localparam int QW = $clog2(QDEPTH);
    localparam logic [QW:0] QFULL = (QW+1)'(QDEPTH);

    localparam logic [2:0] SINGLE = 3'd0, INCR   = 3'd1;
    localparam logic [2:0] WRAP4  = 3'd2, INCR4  = 3'd3;
    localparam logic [2:0] WRAP8  = 3'd4, INCR8  = 3'd5;

    typedef enum logic {ARB, HOLD} state_t;

    state_t          state_q, state_d;
    logic            held_q, held_d;
    logic            last_q, last_d;
    logic            owner_q [QDEPTH];
    logic [4:0]      beats_q [QDEPTH];
    logic [QW-1:0]   wptr_q, aptr_q, dptr_q;
    logic [QW:0]     acnt_q, dcnt_q;
    logic [4:0]      abeat_q, dbeat_q;

    logic            req0, req1;
    logic            full, own_last, locked;
    logic            gnt_vld, gnt_sel, stb_o, push;
    logic            a_vld, d_vld, a_own, d_own;
    logic [4:0]      a_rem, d_rem, req_beats;
    logic            a_beat, d_beat, a_pop, d_adv;
    logic [2:0]      req_type;
    logic [XLEN-1:0] gnt_d;
    logic [PLEN-1:0] gnt_adr;

    assign req0  = bus_io.mst0_stb_i;
    assign req1  = bus_io.mst1_stb_i;
    assign a_vld = acnt_q != '0;
    assign d_vld = dcnt_q != '0;
    // Slots stay occupied until both their data and ack phases are done
    assign full  = (acnt_q == QFULL) || (dcnt_q == QFULL);

    always_comb begin
        own_last = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if ((QW+1)'(i) < acnt_q && owner_q[aptr_q + QW'(i)] == last_q)
                own_last = 1'b1;
        end
    end

    assign locked = (last_q ? bus_io.mst1_lock_i : bus_io.mst0_lock_i) & own_last;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_sel = 1'b0;
        state_d = state_q;
        held_d  = held_q;
        unique case (state_q)
            ARB: begin
                if (!full) begin
                    if (locked) begin
                        gnt_vld = last_q ? req1 : req0;
                        gnt_sel = last_q;
                    end else if (req0 & req1) begin
                        gnt_vld = 1'b1;
                        gnt_sel = ~last_q;
                    end else if (req0 | req1) begin
                        gnt_vld = 1'b1;
                        gnt_sel = req1;
                    end
                end
            end
            HOLD: begin
                gnt_vld = 1'b1;
                gnt_sel = held_q;
            end
            default: ;
        endcase
        stb_o = HRESETn & gnt_vld & (gnt_sel ? req1 : req0);
        push  = stb_o & bus_io.biu_stb_ack_i;
        if (state_q == ARB && stb_o && !bus_io.biu_stb_ack_i) begin
            state_d = HOLD;
            held_d  = gnt_sel;
        end
        if (state_q == HOLD && push) state_d = ARB;
        if (bus_io.biu_err_i) state_d = ARB;
    end

    assign last_d   = push ? gnt_sel : last_q;
    assign req_type = gnt_sel ? bus_io.mst1_type_i : bus_io.mst0_type_i;

    always_comb begin
        req_beats = 5'd16;
        case (req_type)
            SINGLE, INCR:  req_beats = 5'd1;
            WRAP4, INCR4:  req_beats = 5'd4;
            WRAP8, INCR8:  req_beats = 5'd8;
            default:       req_beats = 5'd16;
        endcase
    end

    // A zero counter means the head entry has not started; load from it
    assign a_rem  = (abeat_q != '0) ? abeat_q : beats_q[aptr_q];
    assign d_rem  = (dbeat_q != '0) ? dbeat_q : beats_q[dptr_q];
    assign a_own  = owner_q[aptr_q];
    assign d_own  = owner_q[dptr_q];
    assign a_beat = bus_io.biu_ack_i & a_vld;
    assign d_beat = bus_io.biu_d_ack_i & d_vld;
    assign a_pop  = a_beat & (a_rem == 5'd1);
    assign d_adv  = d_beat & (d_rem == 5'd1);

    always_ff @(posedge HCLK) begin
        if (push) begin
            owner_q[wptr_q] <= gnt_sel;
            beats_q[wptr_q] <= req_beats;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= ARB;
            held_q  <= 1'b0;
            last_q  <= 1'b1;
            wptr_q  <= '0;
            aptr_q  <= '0;
            dptr_q  <= '0;
            acnt_q  <= '0;
            dcnt_q  <= '0;
            abeat_q <= '0;
            dbeat_q <= '0;
        end else if (bus_io.biu_err_i) begin
            state_q <= ARB;
            held_q  <= held_d;
            last_q  <= last_d;
            wptr_q  <= '0;
            aptr_q  <= '0;
            dptr_q  <= '0;
            acnt_q  <= '0;
            dcnt_q  <= '0;
            abeat_q <= '0;
            dbeat_q <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            last_q  <= last_d;
            wptr_q  <= wptr_q + QW'(push);
            aptr_q  <= aptr_q + QW'(a_pop);
            dptr_q  <= dptr_q + QW'(d_adv);
            acnt_q  <= acnt_q + (QW+1)'(push) - (QW+1)'(a_pop);
            dcnt_q  <= dcnt_q + (QW+1)'(push) - (QW+1)'(d_adv);
            if (a_beat) abeat_q <= a_pop ? 5'd0 : a_rem - 5'd1;
            if (d_beat) dbeat_q <= d_adv ? 5'd0 : d_rem - 5'd1;
        end
    end

    assign gnt_adr = gnt_sel ? bus_io.mst1_adri_i : bus_io.mst0_adri_i;
    assign gnt_d   = gnt_sel ? bus_io.mst1_d_i : bus_io.mst0_d_i;

    assign bus_io.biu_stb_o  = stb_o;
    assign bus_io.biu_adri_o = gnt_adr;
    assign bus_io.biu_size_o = gnt_sel ? bus_io.mst1_size_i : bus_io.mst0_size_i;
    assign bus_io.biu_type_o = req_type;
    assign bus_io.biu_prot_o = gnt_sel ? bus_io.mst1_prot_i : bus_io.mst0_prot_i;
    assign bus_io.biu_lock_o = gnt_sel ? bus_io.mst1_lock_i : bus_io.mst0_lock_i;
    assign bus_io.biu_we_o   = gnt_sel ? bus_io.mst1_we_i : bus_io.mst0_we_i;
    assign bus_io.biu_d_o    = d_vld ? (d_own ? bus_io.mst1_d_i : bus_io.mst0_d_i)
                                     : gnt_d;

    assign bus_io.mst0_stb_ack_o = push & ~gnt_sel;
    assign bus_io.mst1_stb_ack_o = push &  gnt_sel;
    assign bus_io.mst0_d_ack_o   = HRESETn & d_beat & ~d_own;
    assign bus_io.mst1_d_ack_o   = HRESETn & d_beat &  d_own;
    assign bus_io.mst0_ack_o     = HRESETn & a_beat & ~a_own;
    assign bus_io.mst1_ack_o     = HRESETn & a_beat &  a_own;
    assign bus_io.mst0_err_o     = HRESETn & bus_io.biu_err_i & a_vld & ~a_own;
    assign bus_io.mst1_err_o     = HRESETn & bus_io.biu_err_i & a_vld &  a_own;

    assign bus_io.mst0_q_o    = bus_io.biu_q_i;
    assign bus_io.mst1_q_o    = bus_io.biu_q_i;
    assign bus_io.mst0_adro_o = bus_io.biu_adro_i;
    assign bus_io.mst1_adro_o = bus_io.biu_adro_i;
endmodule
